phy_rx: RTL and testbench

Receive-side PHY that mirrors the two-lane transmit path. It deserializes two serial lanes. It aligns each lane to the COM symbol that the transmitter sends while idle. It packs each lane's bytes into 32-bit words and un-stripes those words into a single 32-bit stream, lane 0 first and then lane 1 alternately. The block runs entirely in the serial bit-clock domain.

---
 rtl/phy_rx.sv | 179 +++++++++++++++++
 tb/tb_phy_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx.sv
// Two-lane receive PHY: per-lane COM alignment, byte-to-word packing and lane un-striping.
// Optional mid-word COM detection with sticky word_err is enabled by defining PHY_RX_IDLE_CHECK_EN.
module phy_rx #(
    parameter logic [7:0] COM_SYMBOL = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic        clock32,
    input  logic        reset,
    input  logic        data_in0,
    input  logic        data_in1,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        lock0,
    output logic        lock1,
    output logic        overflow
`ifdef PHY_RX_IDLE_CHECK_EN
    ,
    output logic        word_err
`endif
);

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } state_e;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    logic [1:0]        din;
    state_e [1:0]      state_q, state_d;
    logic [1:0][7:0]   sh_q, sh_d;
    logic [1:0][2:0]   bit_cnt_q, bit_cnt_d;
    logic [1:0][3:0]   com_cnt_q, com_cnt_d;
    logic [1:0][1:0]   byte_idx_q, byte_idx_d;
    logic [1:0][31:0]  asm_q, asm_d;
    logic [1:0][31:0]  hold_q, hold_d;
    logic [1:0]        pend_q, pend_d;
    logic [1:0]        done;
    logic              ptr_q, ptr_d;
    logic              emit;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
`ifdef PHY_RX_IDLE_CHECK_EN
    logic              err_q, err_d;
`endif

    assign din = {data_in1, data_in0};

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        com_cnt_d  = com_cnt_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        done       = '0;
        ptr_d      = ptr_q;
        emit       = 1'b0;
        data_d     = data_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q;
`ifdef PHY_RX_IDLE_CHECK_EN
        err_d      = err_q;
`endif

        for (int unsigned n = 0; n < 2; n++) begin
            sh_d[n]      = {sh_q[n][6:0], din[n]};
            bit_cnt_d[n] = bit_cnt_q[n] + 3'd1;
            case (state_q[n])
                SEARCH: begin
                    if (sh_d[n] == COM_SYMBOL) begin
                        bit_cnt_d[n] = '0;
                        com_cnt_d[n] = 4'd1;
                        state_d[n]   = CHECK;
                    end
                end
                CHECK: begin
                    if (bit_cnt_q[n] == 3'd7) begin
                        if (sh_d[n] != COM_SYMBOL) begin
                            com_cnt_d[n] = '0;
                            state_d[n]   = SEARCH;
                        end else if (com_cnt_q[n] + 4'd1 == LOCK_N) begin
                            state_d[n]   = LOCKED;
                        end else begin
                            com_cnt_d[n] = com_cnt_q[n] + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (bit_cnt_q[n] == 3'd7) begin
                        if (sh_d[n] != COM_SYMBOL) begin
                            // slot 0 lands in [31:24]: offset is (3-idx)*8
                            asm_d[n][{~byte_idx_q[n], 3'b000} +: 8] = sh_d[n];
                            byte_idx_d[n] = byte_idx_q[n] + 2'd1;
                            if (byte_idx_q[n] == 2'd3) begin
                                done[n]   = 1'b1;
                                hold_d[n] = asm_d[n];
                            end
                        end
`ifdef PHY_RX_IDLE_CHECK_EN
                        else if (byte_idx_q[n] != 2'd0) begin
                            byte_idx_d[n] = '0;
                            err_d         = 1'b1;
                        end
`endif
                    end
                end
                default: state_d[n] = SEARCH;
            endcase
        end

        if (pend_q[ptr_q]) begin
            emit    = 1'b1;
            data_d  = hold_q[ptr_q];
            valid_d = 1'b1;
            ptr_d   = ~ptr_q;
        end

        // A word emitted on this same edge is not lost, so it is not an overflow
        for (int unsigned n = 0; n < 2; n++) begin
            if (emit && ptr_q == 1'(n)) pend_d[n] = 1'b0;
            if (done[n]) begin
                if (pend_q[n] && !(emit && ptr_q == 1'(n))) ovf_d = 1'b1;
                pend_d[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock32 or posedge reset) begin
        if (reset) begin
            state_q[0] <= SEARCH;
            state_q[1] <= SEARCH;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            com_cnt_q  <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            hold_q     <= '0;
            pend_q     <= '0;
            ptr_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef PHY_RX_IDLE_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
`ifdef PHY_RX_IDLE_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign lock0     = (state_q[0] == LOCKED);
    assign lock1     = (state_q[1] == LOCKED);
    assign overflow  = ovf_q;
`ifdef PHY_RX_IDLE_CHECK_EN
    assign word_err  = err_q;
`endif

endmodule

// File: tb/tb_phy_rx.sv
// Directed self-checking bench for phy_rx: alignment, lock, un-striping, overflow and reset.
module tb_phy_rx;

    logic        clock32;
    logic        reset;
    logic        data_in0;
    logic        data_in1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        lock0;
    logic        lock1;
    logic        overflow;
`ifdef PHY_RX_IDLE_CHECK_EN
    logic        word_err;
`endif

    phy_rx #(
        .COM_SYMBOL (8'hBC),
        .LOCK_COUNT (4)
    ) dut (
        .clock32   (clock32),
        .reset     (reset),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lock0     (lock0),
        .lock1     (lock1),
        .overflow  (overflow)
`ifdef PHY_RX_IDLE_CHECK_EN
        ,
        .word_err  (word_err)
`endif
    );

    initial clock32 = 1'b0;
    always #5 clock32 = ~clock32;

    int          tests = 0;
    int          fails = 0;
    int          cyc;
    int          lock_cyc0;
    int          lock_cyc1;
    int          vcount;
    logic        q0[$];
    logic        q1[$];
    logic [31:0] outq[$];
    int          cycq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outw(input int i);
        if (i < outq.size()) return outq[i];
        return 'x;
    endfunction

    function automatic logic [31:0] outc(input int i);
        if (i < cycq.size()) return 32'(cycq[i]);
        return 'x;
    endfunction

    task automatic clear_log();
        cyc       = 0;
        lock_cyc0 = -1;
        lock_cyc1 = -1;
        vcount    = 0;
        outq.delete();
        cycq.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clock32);
        #1;
        reset = 1'b0;
        clear_log();
    endtask

    task automatic push_byte(input int lane, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (lane == 0) q0.push_back(b[i]);
            else           q1.push_back(b[i]);
        end
    endtask

    task automatic step();
        if (q0.size() != 0) data_in0 = q0.pop_front();
        else                data_in0 = 1'b0;
        if (q1.size() != 0) data_in1 = q1.pop_front();
        else                data_in1 = 1'b0;
        @(posedge clock32);
        #1;
        cyc++;
        if (lock0 && lock_cyc0 < 0) lock_cyc0 = cyc;
        if (lock1 && lock_cyc1 < 0) lock_cyc1 = cyc;
        if (valid_out) begin
            vcount++;
            outq.push_back(data_out);
            cycq.push_back(cyc);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset    = 1'b0;
        data_in0 = 1'b0;
        data_in1 = 1'b0;
        clear_log();

        // Reset values and idle line
        #1 reset = 1'b1;
        #2;
        check("rst_data",  data_out,  32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_lock0", 32'(lock0), 32'h0);
        check("rst_lock1", 32'(lock1), 32'h0);
        check("rst_ovf",   32'(overflow), 32'h0);
        @(posedge clock32);
        #1;
        reset = 1'b0;
        clear_log();
        run(64);
        check("idle_lock0",  32'(lock0), 32'h0);
        check("idle_lock1",  32'(lock1), 32'h0);
        check("idle_vcount", 32'(vcount), 32'h0);

        // Lock-up on both lanes
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_byte(0, 8'hBC);
            push_byte(1, 8'hBC);
        end
        run(32);
        check("lockup_cyc0",   32'(lock_cyc0), 32'd32);
        check("lockup_cyc1",   32'(lock_cyc1), 32'd32);
        check("lockup_vcount", 32'(vcount), 32'h0);

        // Bit slip on lane 0 only
        do_reset();
        for (int i = 0; i < 3; i++) q0.push_back(1'($urandom_range(1, 0)));
        for (int i = 0; i < 4; i++) begin
            push_byte(0, 8'hBC);
            push_byte(1, 8'hBC);
        end
        run(36);
        check("slip_cyc0", 32'(lock_cyc0), 32'd35);
        check("slip_cyc1", 32'(lock_cyc1), 32'd32);

        // Broken lock, then relock
        do_reset();
        push_byte(0, 8'hBC);
        push_byte(0, 8'hBC);
        push_byte(0, 8'h00);
        push_byte(0, 8'h11);
        for (int i = 0; i < 4; i++) push_byte(0, 8'hBC);
        run(32);
        check("broken_lock0", 32'(lock0), 32'h0);
        run(32);
        check("relock_cyc0",  32'(lock_cyc0), 32'd64);
        check("relock_lock1", 32'(lock1), 32'h0);

        // Data after lock: lane 0 word first, lane 1 word next cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_byte(0, 8'hBC);
            push_byte(1, 8'hBC);
        end
        push_byte(0, 8'hDE); push_byte(0, 8'hAD); push_byte(0, 8'hBE); push_byte(0, 8'hEF);
        push_byte(1, 8'h01); push_byte(1, 8'h23); push_byte(1, 8'h45); push_byte(1, 8'h67);
        push_byte(0, 8'hBC);
        push_byte(1, 8'hBC);
        run(70);
        check("data_vcount", 32'(vcount), 32'd2);
        check("data_w0",     outw(0), 32'hDEADBEEF);
        check("data_c0",     outc(0), 32'd65);
        check("data_w1",     outw(1), 32'h01234567);
        check("data_c1",     outc(1), 32'd66);
        check("data_ovf",    32'(overflow), 32'h0);

        // Overflow: lane 1 idles while lane 0 completes three words
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_byte(0, 8'hBC);
            push_byte(1, 8'hBC);
        end
        push_byte(0, 8'h11); push_byte(0, 8'h22); push_byte(0, 8'h33); push_byte(0, 8'h44);
        push_byte(0, 8'h55); push_byte(0, 8'h66); push_byte(0, 8'h77); push_byte(0, 8'h88);
        push_byte(0, 8'h99); push_byte(0, 8'hAA); push_byte(0, 8'hBB); push_byte(0, 8'hCC);
        for (int i = 0; i < 5; i++) push_byte(0, 8'hBC);
        for (int i = 0; i < 12; i++) push_byte(1, 8'hBC);
        push_byte(1, 8'hA1); push_byte(1, 8'hB2); push_byte(1, 8'hC3); push_byte(1, 8'hD4);
        push_byte(1, 8'hBC);
        run(127);
        check("ovf_before", 32'(overflow), 32'h0);
        run(1);
        check("ovf_after",  32'(overflow), 32'h1);
        run(37);
        check("ovf_vcount", 32'(vcount), 32'd3);
        check("ovf_w0",     outw(0), 32'h11223344);
        check("ovf_c0",     outc(0), 32'd65);
        check("ovf_w1",     outw(1), 32'hA1B2C3D4);
        check("ovf_c1",     outc(1), 32'd161);
        check("ovf_w2",     outw(2), 32'h99AABBCC);
        check("ovf_c2",     outc(2), 32'd162);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Asynchronous reset mid-stream with random input
        q0.delete();
        q1.delete();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(1'($urandom_range(1, 0)));
            q1.push_back(1'($urandom_range(1, 0)));
        end
        run(5);
        #2 reset = 1'b1;
        #1;
        check("async_data",  data_out,  32'h0);
        check("async_valid", 32'(valid_out), 32'h0);
        check("async_lock0", 32'(lock0), 32'h0);
        check("async_lock1", 32'(lock1), 32'h0);
        check("async_ovf",   32'(overflow), 32'h0);
        run(3);
        q0.delete();
        q1.delete();
        reset = 1'b0;
        clear_log();
        run(64);
        check("post_lock0",  32'(lock0), 32'h0);
        check("post_lock1",  32'(lock1), 32'h0);
        check("post_vcount", 32'(vcount), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
